// File: rtl/ball_vertical_velocity_ctrl_pkg.sv
// Shared constants and helpers for the ball vertical velocity controller.
// FSM state codes, velocity struct, paddle segment map and load arithmetic.
package ball_vertical_velocity_ctrl_pkg;

  localparam logic [3:0] NEUTRAL_DEF   = 4'd8;
  localparam logic [1:0] SERVE_MAG_DEF = 2'd1;

  localparam logic [0:0] ST_HOLD = 1'b0;
  localparam logic [0:0] ST_PLAY = 1'b1;

  typedef struct packed {
    logic       up;
    logic [1:0] mag;
  } vel_t;

  // Outer segments give the steepest angle, the centre pair flies flat.
  function automatic vel_t seg_vel(input logic [2:0] seg);
    vel_t v;
    case (seg)
      3'd0:    v = '{up: 1'b1, mag: 2'd3};
      3'd1:    v = '{up: 1'b1, mag: 2'd2};
      3'd2:    v = '{up: 1'b1, mag: 2'd1};
      3'd3:    v = '{up: 1'b0, mag: 2'd0};
      3'd4:    v = '{up: 1'b0, mag: 2'd0};
      3'd5:    v = '{up: 1'b0, mag: 2'd1};
      3'd6:    v = '{up: 1'b0, mag: 2'd2};
      default: v = '{up: 1'b0, mag: 2'd3};
    endcase
    return v;
  endfunction

  function automatic logic [3:0] vel_load(input logic [3:0] neutral, input vel_t v);
    return v.up ? (neutral - {2'b00, v.mag}) : (neutral + {2'b00, v.mag});
  endfunction

endpackage

// File: rtl/ball_vertical_velocity_ctrl_if.sv
// Event inputs from paddle/collision logic and committed load value to the vertical counter.
interface ball_vertical_velocity_ctrl_if;
  logic       _vblank;
  logic       serve;
  logic       miss;
  logic       hit;
  logic [2:0] hit_seg;
  logic       wall;
  logic       ab;
  logic       bb;
  logic       cb;
  logic       db;
  logic       vel_up;
  logic [1:0] vel_mag;
  logic       frame_upd;

  modport master (
    output _vblank, serve, miss, hit, hit_seg, wall,
    input  ab, bb, cb, db, vel_up, vel_mag, frame_upd
  );

  modport slave (
    input  _vblank, serve, miss, hit, hit_seg, wall,
    output ab, bb, cb, db, vel_up, vel_mag, frame_upd
  );
endinterface

// File: rtl/ball_vertical_velocity_ctrl_vblank_edge_sync.sv
// Two-flop sampler for an async active-low vblank plus a registered falling-edge pulse.
// Pulse appears 2 edges after the first edge sampling low; no backpressure.
module ball_vertical_velocity_ctrl_vblank_edge_sync (
  input  logic clk,
  input  logic _reset,
  input  logic i_vblank_n,
  output logic o_fall
);

  logic r_v1;
  logic r_v2;
  logic r_fall;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_v1   <= 1'b1;
      r_v2   <= 1'b1;
      r_fall <= 1'b0;
    end else begin
      r_v1   <= i_vblank_n;
      r_v2   <= r_v1;
      r_fall <= r_v2 & ~r_v1;
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/ball_vertical_velocity_ctrl.sv
// Ball vertical velocity sequencer; commits load {db,cb,bb,ab} 3 edges after _vblank falls, no backpressure.
// Optional SERVE_LFSR_EN: serve velocity drawn from an 8-bit LFSR instead of alternating direction.
module ball_vertical_velocity_ctrl
  import ball_vertical_velocity_ctrl_pkg::*;
#(
  parameter logic [3:0] NEUTRAL   = NEUTRAL_DEF,
  parameter logic [1:0] SERVE_MAG = SERVE_MAG_DEF
) (
  input logic                          clk,
  input logic                          _reset,
  ball_vertical_velocity_ctrl_if.slave bus
);

  logic       w_commit;
  logic [0:0] r_state;
  logic [0:0] w_next_state;
  vel_t       r_vel;
  vel_t       w_next_vel;
  vel_t       w_serve_vel;
  logic [3:0] w_load;
  logic       r_frame_upd;
  logic       r_pend_serve;
  logic       r_pend_miss;
  logic       r_pend_hit;
  logic       r_pend_wall;
  logic [2:0] r_pend_seg;

  ball_vertical_velocity_ctrl_vblank_edge_sync u_vblank_sync (
    .clk        (clk),
    ._reset     (_reset),
    .i_vblank_n (bus._vblank),
    .o_fall     (w_commit)
  );

`ifdef SERVE_LFSR_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_lfsr <= 8'h01;
    end else begin
      r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
  end

  always_comb begin
    w_serve_vel.up  = r_lfsr[0];
    w_serve_vel.mag = (r_lfsr[2:1] == 2'd0) ? SERVE_MAG : r_lfsr[2:1];
  end
`else
  logic r_serve_dir;

  // Direction flips on every committed serve so consecutive serves alternate.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_serve_dir <= 1'b0;
    end else if (w_commit && r_pend_serve) begin
      r_serve_dir <= ~r_serve_dir;
    end
  end

  assign w_serve_vel = {r_serve_dir, SERVE_MAG};
`endif

  // A serve in PLAY behaves as miss-then-serve, so it outranks every other event.
  always_comb begin
    w_next_state = r_state;
    w_next_vel   = r_vel;
    if (r_pend_serve) begin
      w_next_vel   = w_serve_vel;
      w_next_state = ST_PLAY;
    end else if (r_state == ST_HOLD) begin
      w_next_vel = '0;
    end else if (r_pend_miss) begin
      w_next_vel   = '0;
      w_next_state = ST_HOLD;
    end else if (r_pend_hit) begin
      w_next_vel = seg_vel(r_pend_seg);
    end else if (r_pend_wall) begin
      w_next_vel.up = ~r_vel.up;
    end
    if (w_next_vel.mag == 2'd0) begin
      w_next_vel.up = 1'b0;
    end
  end

  // Pulses landing on the commit edge seed the next frame's pending set.
  always_ff @(posedge clk) begin
    if (!_reset) begin
      r_state      <= ST_HOLD;
      r_vel        <= '0;
      r_frame_upd  <= 1'b0;
      r_pend_serve <= 1'b0;
      r_pend_miss  <= 1'b0;
      r_pend_hit   <= 1'b0;
      r_pend_wall  <= 1'b0;
      r_pend_seg   <= 3'd0;
    end else begin
      r_frame_upd <= w_commit;
      if (w_commit) begin
        r_state      <= w_next_state;
        r_vel        <= w_next_vel;
        r_pend_serve <= bus.serve;
        r_pend_miss  <= bus.miss;
        r_pend_hit   <= bus.hit;
        r_pend_wall  <= bus.wall;
      end else begin
        r_pend_serve <= r_pend_serve | bus.serve;
        r_pend_miss  <= r_pend_miss | bus.miss;
        r_pend_hit   <= r_pend_hit | bus.hit;
        r_pend_wall  <= r_pend_wall | bus.wall;
      end
      if (bus.hit) begin
        r_pend_seg <= bus.hit_seg;
      end
    end
  end

  assign w_load        = vel_load(NEUTRAL, r_vel);
  assign bus.ab        = w_load[0];
  assign bus.bb        = w_load[1];
  assign bus.cb        = w_load[2];
  assign bus.db        = w_load[3];
  assign bus.vel_up    = r_vel.up;
  assign bus.vel_mag   = r_vel.mag;
  assign bus.frame_upd = r_frame_upd;

endmodule

// File: tb/tb_ball_vertical_velocity_ctrl.sv
// Scoreboard bench: frame-level reference model queues expected commits, a monitor compares every cycle.
module tb_ball_vertical_velocity_ctrl;

  logic clk = 1'b0;
  logic _reset;

  ball_vertical_velocity_ctrl_if bus ();

  ball_vertical_velocity_ctrl dut (
    .clk    (clk),
    ._reset (_reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state (frame-level, plain integers).
  int   m_state;
  int   m_up;
  int   m_mag;
  int   m_dir;
  bit   p_serve, p_miss, p_hit, p_wall;
  int   p_seg;
  bit   prev_vb;
  int   since_fall;
  int   seg_up  [8] = '{1, 1, 1, 0, 0, 0, 0, 0};
  int   seg_mag [8] = '{3, 2, 1, 0, 0, 1, 2, 3};

  logic [6:0] sb_q[$];
  logic [6:0] exp_cur;
  logic [6:0] mon_act;
  bit         mon_en = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  function automatic logic [6:0] pack_exp(input int up, input int mag);
    int         ld;
    logic [3:0] l4;
    ld = 8 + ((up != 0) ? -mag : mag);
    l4 = ld[3:0];
    return {l4, up[0], mag[1:0]};
  endfunction

  task automatic model_commit();
    if (p_serve) begin
      m_up    = m_dir;
      m_mag   = 1;
      m_dir   = 1 - m_dir;
      m_state = 1;
    end else if (m_state == 0) begin
      m_up  = 0;
      m_mag = 0;
    end else if (p_miss) begin
      m_up    = 0;
      m_mag   = 0;
      m_state = 0;
    end else if (p_hit) begin
      m_up  = seg_up[p_seg];
      m_mag = seg_mag[p_seg];
    end else if (p_wall) begin
      m_up = (m_up == 0) ? 1 : 0;
    end
    if (m_mag == 0) m_up = 0;
    sb_q.push_back(pack_exp(m_up, m_mag));
    p_serve = 0;
    p_miss  = 0;
    p_hit   = 0;
    p_wall  = 0;
  endtask

  task automatic step(input bit vb, input bit s, input bit m, input bit h,
                      input logic [2:0] seg, input bit w);
    @(negedge clk);
    _reset      = 1'b1;
    bus._vblank = vb;
    bus.serve   = s;
    bus.miss    = m;
    bus.hit     = h;
    bus.hit_seg = seg;
    bus.wall    = w;
    if (!vb && prev_vb) since_fall = 0;
    else if (since_fall >= 0) since_fall++;
    if (since_fall == 2) begin
      model_commit();
      since_fall = -1;
    end
    if (s) p_serve = 1;
    if (m) p_miss = 1;
    if (h) begin
      p_hit = 1;
      p_seg = int'(seg);
    end
    if (w) p_wall = 1;
    prev_vb = vb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    _reset      = 1'b0;
    bus._vblank = 1'b1;
    bus.serve   = 1'b0;
    bus.miss    = 1'b0;
    bus.hit     = 1'b0;
    bus.hit_seg = 3'd0;
    bus.wall    = 1'b0;
    m_state = 0; m_up = 0; m_mag = 0; m_dir = 0;
    p_serve = 0; p_miss = 0; p_hit = 0; p_wall = 0; p_seg = 0;
    prev_vb    = 1'b1;
    since_fall = -1;
    sb_q.delete();
    exp_cur = pack_exp(0, 0);
    mon_en  = 1'b1;
  endtask

  // Fixed-shape frame: events in the active phase, optional wall on the commit edge.
  task automatic frame(input bit s, input bit m, input bit h, input logic [2:0] seg,
                       input int nwall, input bit wc);
    step(1, s, 0, 0, 3'd0, 0);
    step(1, 0, m, 0, 3'd0, 0);
    step(1, 0, 0, h, seg, 0);
    step(1, 0, 0, 0, 3'd0, nwall >= 1);
    step(1, 0, 0, 0, 3'd0, nwall >= 2);
    step(0, 0, 0, 0, 3'd0, 0);
    step(0, 0, 0, 0, 3'd0, 0);
    step(0, 0, 0, 0, 3'd0, wc);
    step(1, 0, 0, 0, 3'd0, 0);
    step(1, 0, 0, 0, 3'd0, 0);
  endtask

  task automatic rand_step(input bit vb);
    step(vb, $urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
         $urandom_range(0, 9) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 9) == 0);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      mon_act = {bus.db, bus.cb, bus.bb, bus.ab, bus.vel_up, bus.vel_mag};
      if (bus.frame_upd === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL commit_unexpected t=%0t frame_upd=1 with no commit due", $time);
        end else begin
          exp_cur = sb_q.pop_front();
        end
      end else if (bus.frame_upd !== 1'b0) begin
        n_vec++;
        n_err++;
        $display("FAIL frame_upd_x t=%0t actual=%b required=0/1", $time, bus.frame_upd);
      end
      n_vec++;
      if (mon_act !== exp_cur) begin
        n_err++;
        $display("FAIL outputs t=%0t actual load=%0d up=%b mag=%0d required load=%0d up=%b mag=%0d",
                 $time, mon_act[6:3], mon_act[2], mon_act[1:0],
                 exp_cur[6:3], exp_cur[2], exp_cur[1:0]);
      end
    end
  end

  initial begin
    int act_len;
    int vbl_len;
    _reset      = 1'b0;
    bus._vblank = 1'b1;
    bus.serve   = 1'b0;
    bus.miss    = 1'b0;
    bus.hit     = 1'b0;
    bus.hit_seg = 3'd0;
    bus.wall    = 1'b0;
    do_reset();

    frame(1, 0, 0, 3'd0, 0, 0);   // serve -> 9
    frame(0, 1, 0, 3'd0, 0, 0);   // miss -> 8
    frame(1, 0, 0, 3'd0, 0, 0);   // second serve, up -> 7
    frame(0, 0, 1, 3'd0, 0, 0);   // seg0 -> 5
    frame(0, 0, 1, 3'd7, 0, 0);   // seg7 -> 11
    frame(0, 0, 1, 3'd4, 0, 0);   // seg4 -> 8
    frame(0, 0, 1, 3'd6, 0, 0);   // seg6 -> 10
    frame(0, 0, 0, 3'd0, 2, 0);   // two walls, one flip -> 6
    frame(0, 0, 0, 3'd0, 0, 0);   // no event -> 6
    frame(0, 0, 1, 3'd6, 1, 0);   // hit beats wall -> 10
    frame(0, 1, 1, 3'd0, 0, 0);   // miss beats hit -> 8
    frame(1, 0, 0, 3'd0, 0, 0);   // third serve -> 9
    frame(0, 0, 0, 3'd0, 0, 1);   // wall on commit edge deferred -> 9
    frame(0, 0, 0, 3'd0, 0, 0);   // deferred wall applied -> 7
    frame(0, 0, 1, 3'd0, 0, 0);   // vel 3 up -> 5
    step(1, 0, 0, 0, 3'd0, 0);
    do_reset();                    // mid-frame reset -> 8, HOLD
    frame(0, 0, 1, 3'd3, 1, 0);   // HOLD ignores hit/wall -> 8
    frame(1, 0, 0, 3'd0, 0, 0);   // serve after reset starts down -> 9

    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 24) == 0) do_reset();
      act_len = $urandom_range(3, 15);
      for (int i = 0; i < act_len; i++) rand_step(1);
      vbl_len = $urandom_range(1, 5);
      for (int i = 0; i < vbl_len; i++) rand_step(0);
      for (int i = 0; i < 2; i++) rand_step(1);
    end

    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 3'd0, 0);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL commits_missing actual_outstanding=%0d required=0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
